// File: rtl/ntt_perm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ntt_perm_pkg : index maps and per-frame mode record for the NTT permutation
// Rev 1.0
// ---------------------------------------------------------------------------
package ntt_perm_pkg;

  localparam int MODE_SEL_W = 8;

  typedef struct packed {
    logic                  bitrev_en;
    logic [MODE_SEL_W-1:0] stage_sel;
  } frame_mode_t;

  // Rotate a log_n-bit index left by s; out-of-range amounts map to identity.
  function automatic int rotl_idx(input int k, input int s, input int log_n);
    int mask;
    mask = (1 << log_n) - 1;
    if (s <= 0 || s >= log_n) return k & mask;
    return ((k << s) | (k >> (log_n - s))) & mask;
  endfunction

  function automatic int bitrev_idx(input int k, input int log_n);
    int r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if (b < log_n) r = (r << 1) | ((k >> b) & 1);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perm_frame_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// perm_frame_bank : one N x W frame store, beat-wide write, P-way random read
// Rev 1.0
// ---------------------------------------------------------------------------
module perm_frame_bank #(
  parameter int W     = 28,
  parameter int N     = 1024,
  parameter int P     = 128,
  parameter int LOG_N = $clog2(N),
  parameter int CNT_W = ((N / P) > 1) ? $clog2(N / P) : 1
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [CNT_W-1:0]   beat_i,
  input  logic [P*W-1:0]     wdata_i,
  input  logic [P*LOG_N-1:0] raddr_i,
  output logic [P*W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int j = 0; j < P; j++) begin
        mem_q[LOG_N'(int'(beat_i) * P + j)] <= wdata_i[j*W +: W];
      end
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_rd
    assign rdata_o[i*W +: W] = mem_q[raddr_i[i*LOG_N +: LOG_N]];
  end

endmodule
`default_nettype wire

// File: rtl/stage_generic_permutation.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage_generic_permutation : ping-pong streaming rotation / bit-reverse stage
// Rev 1.0
// ---------------------------------------------------------------------------
module stage_generic_permutation
  import ntt_perm_pkg::*;
#(
  parameter  int DATA_WIDTH_PER_INPUT = 28,
  parameter  int INPUT_PER_CYCLE      = 128,
  parameter  int N_POINTS             = 1024,
  localparam int LOG_N  = $clog2(N_POINTS),
  localparam int CYCLES = N_POINTS / INPUT_PER_CYCLE,
  localparam int SEL_W  = (LOG_N > 1) ? $clog2(LOG_N) : 1,
  localparam int W      = DATA_WIDTH_PER_INPUT,
  localparam int P      = INPUT_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [P*W-1:0]   inData,
  input  logic             in_start,
  input  logic [SEL_W-1:0] stage_sel,
  input  logic             bitrev_en,
  output logic [P*W-1:0]   outData,
  output logic             out_start,
  output logic             out_valid
);

  localparam int         CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_FILL   = 1'b1;
  localparam logic [0:0] S_DRAIN  = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CYCLES - 1);

  logic [0:0]       in_state_q, in_state_d, out_state_q, out_state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  frame_mode_t      mode_q [2];
  frame_mode_t      w_mode_in, w_rd_mode;
  logic             w_launch, w_wr_en, w_rd_en;
  logic [CNT_W-1:0] w_wr_beat;
  logic [P*LOG_N-1:0] w_raddr;
  logic [P*W-1:0]   w_rdata_a, w_rdata_b, w_rdata;
  logic [P*W-1:0]   out_data_q;
  logic             out_start_q, out_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_state_q  <= S_IDLE;
      out_state_q <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      mode_q[0]   <= '0;
      mode_q[1]   <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      if (in_start) mode_q[wr_bank_q] <= w_mode_in;
    end
  end

  // A new in_start always restarts at beat 0 of the current write bank.
  always_comb begin
    in_state_d  = in_state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    w_launch    = 1'b0;
    if (in_start) begin
      if (CYCLES == 1) begin
        w_launch   = 1'b1;
        wr_bank_d  = ~wr_bank_q;
        in_state_d = S_IDLE;
      end else begin
        in_state_d = S_FILL;
        wr_cnt_d   = CNT_W'(1);
      end
    end else if (in_state_q == S_FILL) begin
      if (wr_cnt_q == LAST_BEAT) begin
        w_launch   = 1'b1;
        wr_bank_d  = ~wr_bank_q;
        wr_cnt_d   = '0;
        in_state_d = S_IDLE;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    out_state_d = out_state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    if (out_state_q == S_DRAIN) begin
      if (rd_cnt_q == LAST_BEAT) begin
        out_state_d = S_IDLE;
        rd_cnt_d    = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
    // A launch coincides at most with the last read beat of the previous frame.
    if (w_launch) begin
      out_state_d = S_DRAIN;
      rd_cnt_d    = '0;
      rd_bank_d   = wr_bank_q;
    end
  end

  always_comb begin
    w_mode_in.bitrev_en = bitrev_en;
    w_mode_in.stage_sel = MODE_SEL_W'(stage_sel);
    w_wr_en   = rst && (in_start || (in_state_q == S_FILL));
    w_wr_beat = in_start ? '0 : wr_cnt_q;
    w_rd_en   = (out_state_q == S_DRAIN);
    w_rd_mode = mode_q[rd_bank_q];
    w_raddr   = '0;
    for (int i = 0; i < P; i++) begin
      int k, src;
      k   = int'(rd_cnt_q) * P + i;
      src = w_rd_mode.bitrev_en ? bitrev_idx(k, LOG_N)
                                : rotl_idx(k, int'(w_rd_mode.stage_sel), LOG_N);
      w_raddr[i*LOG_N +: LOG_N] = LOG_N'(src);
    end
    w_rdata = rd_bank_q ? w_rdata_b : w_rdata_a;
  end

  perm_frame_bank #(.W(W), .N(N_POINTS), .P(P)) u_bank_a (
    .clk_i   (clk),
    .we_i    (w_wr_en && !wr_bank_q),
    .beat_i  (w_wr_beat),
    .wdata_i (inData),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata_a)
  );

  perm_frame_bank #(.W(W), .N(N_POINTS), .P(P)) u_bank_b (
    .clk_i   (clk),
    .we_i    (w_wr_en && wr_bank_q),
    .beat_i  (w_wr_beat),
    .wdata_i (inData),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= w_rd_en;
      out_start_q <= w_rd_en && (rd_cnt_q == '0);
      if (w_rd_en) out_data_q <= w_rdata;
    end
  end

  assign outData   = out_data_q;
  assign out_start = out_start_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_generic_permutation.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stage_generic_permutation : scoreboard bench for the permutation stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_stage_generic_permutation;

  localparam int W = 28;
  localparam int P = 128;
  localparam int N = 1024;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [P*W-1:0] inData;
  logic           in_start;
  logic [3:0]     stage_sel;
  logic           bitrev_en;
  logic [P*W-1:0] outData;
  logic           out_start;
  logic           out_valid;

  always #5 clk = ~clk;

  stage_generic_permutation #(
    .DATA_WIDTH_PER_INPUT (W),
    .INPUT_PER_CYCLE      (P),
    .N_POINTS             (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inData    (inData),
    .in_start  (in_start),
    .stage_sel (stage_sel),
    .bitrev_en (bitrev_en),
    .outData   (outData),
    .out_start (out_start),
    .out_valid (out_valid)
  );

  typedef struct {
    int             cyc;
    bit             start;
    logic [P*W-1:0] data;
  } exp_t;

  exp_t           exp_q[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  int             cur_run = 0;
  int             max_run = 0;
  int             ob = 0;
  int             last_e0 = 0;
  logic [P*W-1:0] obs [C];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int lane(input logic [P*W-1:0] v, input int j);
    return int'(v[j*W +: W]);
  endfunction

  function automatic int m_src(input int k, input int sel, input bit br);
    int r;
    r = 0;
    if (br) begin
      for (int b = 0; b < 10; b++) r = r | (((k >> b) & 1) << (9 - b));
      return r;
    end
    if (sel == 0 || sel >= 10) return k;
    return ((k << sel) | (k >> (10 - sel))) & 1023;
  endfunction

  task automatic push_frame(input int e0, input int base, input int sel, input bit br);
    exp_t e;
    for (int r = 0; r < C; r++) begin
      e.cyc   = e0 + C + r;
      e.start = (r == 0);
      for (int i = 0; i < P; i++) e.data[i*W +: W] = W'(base + m_src(r*P + i, sel, br));
      exp_q.push_back(e);
    end
  endtask

  task automatic beats(input int base, input int sel, input bit br, input int nb, input bit push);
    int e0;
    e0 = 0;
    for (int b = 0; b < nb; b++) begin
      @(posedge clk); #2;
      in_start = (b == 0);
      if (b == 0) begin
        stage_sel = 4'(sel);
        bitrev_en = br;
        e0 = cyc + 1;
      end
      for (int j = 0; j < P; j++) inData[j*W +: W] = W'(base + b*P + j);
    end
    if (push) push_frame(e0, base, sel, br);
    last_e0 = e0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Monitor: pops one expected beat per valid output cycle.
  always @(negedge clk) begin
    exp_t e;
    chk("start_without_valid", int'(out_start && !out_valid), 0);
    if (out_valid) begin
      cur_run++;
      if (out_start) ob = 0;
      if (ob < C) obs[ob] = outData;
      ob++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_cycle", cyc, e.cyc);
        chk("beat_out_start", int'(out_start), int'(e.start));
        begin
          int bad;
          bad = -1;
          for (int i = P - 1; i >= 0; i--) if (outData[i*W +: W] !== e.data[i*W +: W]) bad = i;
          if (bad < 0) chk("beat_data", 0, 0);
          else chk($sformatf("beat_data_lane%0d", bad), lane(outData, bad), lane(e.data, bad));
        end
      end
    end else begin
      if (cur_run > max_run) max_run = cur_run;
      cur_run = 0;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_out_valid", 0, 1);
      end
    end
  end

  initial begin
    rst = 1'b0; in_start = 1'b0; inData = '0; stage_sel = '0; bitrev_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_start", int'(out_start), 0);
    chk("rst_outData_any", int'(|outData), 0);
    @(posedge clk); #2;
    rst = 1'b1;

    max_run = 0;
    beats(0, 0, 0, C, 1); wait_drain();
    chk("id_valid_len", max_run, 8);
    chk("id_b0_l5", lane(obs[0], 5), 5);
    chk("id_b2_l3", lane(obs[2], 3), 259);
    chk("id_b7_l127", lane(obs[7], 127), 1023);

    beats(0, 3, 0, C, 1); wait_drain();
    chk("rot3_b0_l1", lane(obs[0], 1), 8);
    chk("rot3_b0_l127", lane(obs[0], 127), 1016);
    chk("rot3_b1_l0", lane(obs[1], 0), 1);

    beats(0, 12, 0, C, 1); wait_drain();
    chk("rot12_b0_l1", lane(obs[0], 1), 1);
    chk("rot12_b3_l7", lane(obs[3], 7), 391);

    beats(0, 5, 1, C, 1); wait_drain();
    chk("brev_b0_l1", lane(obs[0], 1), 512);
    chk("brev_b1_l0", lane(obs[1], 0), 4);
    chk("brev_b7_l127", lane(obs[7], 127), 1023);

    max_run = 0;
    beats(0, 0, 0, C, 1);
    beats(1024, 0, 1, C, 1);
    beats(0, 1, 0, C, 1);
    wait_drain();
    chk("b2b_valid_len", max_run, 24);
    chk("b2b_f3_b0_l1", lane(obs[0], 1), 2);
    chk("b2b_f3_b4_l0", lane(obs[4], 0), 1);

    max_run = 0;
    beats(5000, 3, 0, 3, 0);
    beats(0, 0, 1, C, 1);
    wait_drain();
    chk("restart_valid_len", max_run, 8);
    chk("restart_b0_l1", lane(obs[0], 1), 512);
    chk("restart_b1_l0", lane(obs[1], 0), 4);

    beats(0, 0, 0, C, 1);
    begin
      int t, e0;
      e0 = last_e0;
      t = 0;
      while (cyc < e0 + C + 3 && t < 100) begin
        @(posedge clk); #2;
        t++;
      end
      chk("reset_wait_timeout", int'(t >= 100), 0);
      rst = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].cyc >= e0 + C + 4) void'(exp_q.pop_back());
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_start", int'(out_start), 0);
      chk("midrst_outData_any", int'(|outData), 0);
    end
    repeat (6) @(posedge clk);
    #2;
    beats(2000, 3, 0, C, 1); wait_drain();
    chk("post_rst_b0_l1", lane(obs[0], 1), 2008);
    chk("post_rst_b1_l0", lane(obs[1], 0), 2001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_generic_permutation.md
Name: stage_generic_permutation

Overview:
- Parametrised streaming permutation that replaces the fixed per-stage stage_N_permutation blocks between NTT butterfly stages.
- Accepts an N-element frame as P lanes per cycle over C = N/P consecutive cycles and emits the same frame reordered.
- The reordering is a runtime-selected index rotation (stride permutation) or a bit-reversal.
- Ping-pong frame buffering sustains back-to-back frames at full throughput.

Parameters:
- DATA_WIDTH_PER_INPUT, 28, bits per element.
- INPUT_PER_CYCLE, 128, lanes per beat (P); power of two, P <= N_POINTS.
- N_POINTS, 1024, elements per frame (N); power of two.
- Derived localparams: LOG_N = $clog2(N_POINTS); CYCLES = N_POINTS/INPUT_PER_CYCLE; SEL_W = max(1,$clog2(LOG_N)).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- inData  input  P*W  lane i at [i*W +: W]; W = DATA_WIDTH_PER_INPUT.
- in_start  input  1  pulse marking beat 0 of an input frame.
- stage_sel  input  SEL_W  rotation amount; sampled with in_start.
- bitrev_en  input  1  selects bit-reversal; overrides stage_sel; sampled with in_start.
- outData  output  P*W  permuted lanes, same packing as inData.
- out_start  output  1  high on output beat 0 only.
- out_valid  output  1  high on all CYCLES output beats.

Behaviour:
- Element index k = beat*P + lane, for 0 <= k < N. The input frame is written in natural order.
- Output index k takes input element src(k):
  - bitrev_en = 1: src(k) = bitrev_LOGN(k).
  - otherwise: src(k) = rotl_LOGN(k, stage_sel).
  - stage_sel >= LOG_N is treated as 0 (identity).
- Input framing:
  - Beat 0 is sampled at the edge where in_start = 1; beats 1..C-1 are sampled unconditionally on the next C-1 edges.
  - There is no per-beat valid.
  - stage_sel and bitrev_en are latched per frame at beat 0.
- Frame restart: in_start = 1 during beats 1..C-1 aborts the partial frame. That edge becomes beat 0 into the same bank and re-latches the mode. The bank does not toggle.
- Ping-pong banks A/B:
  - The write bank toggles at the edge that samples beat C-1.
  - Readout of the completed bank starts at the next edge.
- Latency: if beat 0 is sampled at edge e0, output beat r is registered at edge e(C+r). out_start and out_valid are visible in the cycle after e(C), i.e. C cycles of latency.
- Outputs are registered:
  - Output beat r, lane i = element src(r*P+i) of the read bank.
  - The read is combinational off bank storage and captured at the edge.
- Back-to-back frames:
  - in_start on the edge after beat C-1 is legal; output is then continuous with no gap.
  - The final read of bank X (edge e(2C-1)) precedes frame f+2's first write to X (edge e(2C)), so there is no hazard.
- Each readout uses the mode latched with its own frame, so modes may differ frame to frame.
- Idle: after the last output beat, out_valid = 0, out_start = 0 and outData holds its last value.
- CYCLES = 1 (N = P) is legal: every beat is a whole frame, and the output follows 1 cycle later.
- Reset (rst = 0 at an edge):
  - Clears the input beat counter, write/read bank pointers, read counter and readout-active flag.
  - out_start = 0, out_valid = 0, outData = 0.
  - Bank storage is not cleared.
  - Any in-flight input or output frame is discarded; an in_start on the first edge with rst = 1 begins a fresh frame.
- in_start sampled while rst = 0 is ignored.
- State machine: input side IDLE / FILL (beat counter 0..C-1); output side IDLE / DRAIN (read counter 0..C-1). The two are independent apart from the bank handoff.

Decomposition:
- Package ntt_perm_pkg holds:
  - Functions rotl_idx(k, s, LOG_N) and bitrev_idx(k, LOG_N).
  - A frame-mode struct {bitrev_en, stage_sel}.
- Sub-module perm_frame_bank holds one N×W register bank:
  - Write port: P lanes at beat address.
  - Read port: P arbitrary element indices.
  - Instantiated twice.

Test Plan (N=1024, P=128, W=28; input element value = index, i.e. inData lane j of beat b = 128b+j):
- Identity: stage_sel = 0, bitrev_en = 0.
  - Required: out_start 8 cycles after the in_start edge; beat b lane j = 128b+j; out_valid high exactly 8 cycles.
- Rotation: stage_sel = 3.
  - Required: beat 0 lane 1 = 8; beat 0 lane 127 = 1016; beat 1 lane 0 = 1; stage_sel = 12 behaves as identity.
- Bit-reversal: bitrev_en = 1, stage_sel = 5.
  - Required: beat 0 lane 1 = 512; beat 1 lane 0 = 4; beat 7 lane 127 = 1023.
- Back-to-back: three frames on consecutive 8-cycle slots with modes identity / bitrev / stage_sel = 1 (second frame values +1024).
  - Required: 24 contiguous out_valid cycles; out_start at output beats 0, 8, 16; each frame permuted by its own mode.
- Restart: in_start, 3 beats, then in_start again with a new frame.
  - Required: only the second frame is output; out_start 8 cycles after the second in_start.
- Reset mid-drain: rst = 0 for 1 cycle at output beat 4.
  - Required: out_valid = 0 and outData = 0 next cycle, no further beats; a fresh frame afterwards is correct.
